naive_cpu: RTL and testbench
============================

Name: naive_cpu

Overview:
- Minimal 16-bit, two-stage (fetch / execute) accumulator-style CPU core.
- Fetches 16-bit instructions from an external instruction ROM and executes them against a 16-entry x 16-bit register file.
- Provides a combinational observation port that exposes internal state to the board/debug logic.
- Sits between the instruction ROM and the debug/display logic at the top level.

Parameters:
- DATA_W, 16, register/data width (RegBus)
- REG_AW, 4, register address width (RegAddrBus); 16 registers
- INST_W, 16, instruction width (InstBus)
- PC_W, 16, instruction address width (InstAddrBus)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- rom_data_i  input  16  instruction word returned by ROM for rom_addr_o (combinational ROM)
- rom_addr_o  output  16  instruction fetch address (= PC)
- rom_ce_o  output  1  ROM chip enable
- ob_mode_i  input  3  observation mode select
- ob_sel  input  4  register index for observation mode 0
- ob_data_o  output  16  observed value

Behaviour:
- Reset: while rst=0 (asynchronous assert), PC=0, IR=0 (NOP), all registers=0, last ALU result=0, rom_ce_o=0. rom_ce_o=1 from the first rising edge after rst goes to 1.
- Fetch, every edge with rom_ce_o=1:
  - IR <= rom_data_i; PC <= PC+1, wrapping at 0xFFFF->0.
  - On the first edge after reset release only rom_ce_o rises; no fetch happens.
- Execute: decodes IR combinationally and writes its result on the same edge that loads the next IR.
  - Latency: instruction at address A is fetched on edge N; its result is visible in the register file after edge N+1.
  - Two-stage pipeline means no data hazards: the write completes before the next instruction reads.
- Encoding: op=IR[15:10], rd=IR[9:6], imm6=IR[5:0], rs=IR[5:2], fn=IR[1:0], imm10=IR[9:0].
- Opcodes:
  - 000000 NOP.
  - 001101 ORI: rd <= rd | zext(imm6).
  - 001100 ANDI: rd <= rd & zext(imm6).
  - 001110 XORI: rd <= rd ^ zext(imm6).
  - 001000 ADDI: rd <= rd + sext(imm6), modulo 2^16.
  - 000001 R-type: rd <= rd op rs. fn 00 ADD, 01 SUB (rd-rs), 10 AND, 11 OR. Arithmetic is modulo 2^16, no flags.
  - 000100 JMP: PC <= zext(imm10), and the already-fetched sequential instruction is squashed (IR <= NOP).
  - Any other opcode executes as NOP.
- Register 0 reads as 0 at all times; writes to it are discarded.
- Last ALU result register captures every computed write value, including values targeted at r0.
- Observation port, purely combinational; reflects updated state right after the write edge:
  - ob_mode_i 0: register[ob_sel]
  - 1: PC
  - 2: IR
  - 3: last ALU result
  - 4-7: 0x0000
- Reset mid-operation: asynchronous clear of all state; the in-flight instruction is lost and fetch restarts at 0.

Optional Feature:
- Macro: NAIVE_CPU_HALT_EN.
- When defined:
  - Opcode 111111 is HALT. On execute, PC and IR freeze and further register writes stop until reset.
  - rom_ce_o drops to 0 while halted.
  - ob_mode_i 4 returns {15'b0, halted}.
- When undefined:
  - 111111 executes as NOP.
  - Mode 4 returns 0.

Test Plan:
- Reset check: hold rst=0 for 4 cycles -> rom_addr_o=0, rom_ce_o=0, ob_data_o=0 in every mode. Release rst -> rom_ce_o=1 after the first edge, then PC increments by 1 per cycle.
- Constant ORI stream: rom_data_i=0x3443 (ORI r1,3) permanently, ob_mode_i=0, ob_sel=1 -> r1 reads 0 until the second fetch edge, then 3 and stays 3. ob_mode_i=3 -> 0x0003. ob_sel=0 -> 0.
- Arithmetic:
  - ADDI r2,-1 (0x20BF) on r2=0 -> r2=0xFFFF.
  - Then R-type SUB r2,r1 (0x0485) with r1=3 -> r2=0xFFFC.
- Jump: JMP 0x020 at address 5 -> instruction at address 6 not executed (its target register unchanged), rom_addr_o goes 0x0020 then 0x0021.
- Async reset mid-run: drop rst between clock edges after r1=3 -> r1, PC, IR clear immediately without a clock edge.
- NAIVE_CPU_HALT_EN defined: HALT at address 2 -> PC stops at 3, rom_ce_o=0, mode 4 returns 0x0001. Without the macro, PC keeps incrementing.

Source files
------------

// File: rtl/naive_cpu.sv
// naive_cpu: two-stage (fetch/execute) 16-bit accumulator CPU with a 16 x 16-bit register file.
// Optional macro NAIVE_CPU_HALT_EN adds the HALT opcode (111111) and the halted flag on observation mode 4.
module naive_cpu #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int INST_W = 16,
  parameter int PC_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INST_W-1:0] rom_data_i,
  output logic [PC_W-1:0]   rom_addr_o,
  output logic              rom_ce_o,
  input  logic [2:0]        ob_mode_i,
  input  logic [REG_AW-1:0] ob_sel,
  output logic [DATA_W-1:0] ob_data_o
);

  localparam int NREG = 1 << REG_AW;

  localparam logic [5:0] OP_RTYPE = 6'b000001;
  localparam logic [5:0] OP_JMP   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
`ifdef NAIVE_CPU_HALT_EN
  localparam logic [5:0] OP_HALT  = 6'b111111;
`endif

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [INST_W-1:0] ir_q, ir_d;
  logic              ce_q, ce_d;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] regs_q [NREG];

  logic [5:0]        op_s;
  logic [REG_AW-1:0] rd_s, rs_s;
  logic [1:0]        fn_s;
  logic [5:0]        imm6_s;
  logic [DATA_W-1:0] rd_val_s, rs_val_s, zimm_s, simm_s, wr_val_s;
  logic              wr_en_s, jmp_s, halt_s, halted_s;

  assign op_s     = ir_q[15:10];
  assign rd_s     = ir_q[9:6];
  assign rs_s     = ir_q[5:2];
  assign fn_s     = ir_q[1:0];
  assign imm6_s   = ir_q[5:0];
  assign rd_val_s = (rd_s == '0) ? '0 : regs_q[rd_s];
  assign rs_val_s = (rs_s == '0) ? '0 : regs_q[rs_s];
  assign zimm_s   = {{(DATA_W-6){1'b0}}, imm6_s};
  assign simm_s   = {{(DATA_W-6){imm6_s[5]}}, imm6_s};

  assign rom_addr_o = pc_q;
  assign rom_ce_o   = ce_q;

  // Execute-stage decode: produces the write-back value and control-flow requests.
  always_comb begin
    wr_en_s  = 1'b0;
    wr_val_s = '0;
    jmp_s    = 1'b0;
    halt_s   = 1'b0;
    case (op_s)
      OP_ORI:  begin wr_en_s = 1'b1; wr_val_s = rd_val_s | zimm_s; end
      OP_ANDI: begin wr_en_s = 1'b1; wr_val_s = rd_val_s & zimm_s; end
      OP_XORI: begin wr_en_s = 1'b1; wr_val_s = rd_val_s ^ zimm_s; end
      OP_ADDI: begin wr_en_s = 1'b1; wr_val_s = rd_val_s + simm_s; end
      OP_RTYPE: begin
        wr_en_s = 1'b1;
        case (fn_s)
          2'b00:   wr_val_s = rd_val_s + rs_val_s;
          2'b01:   wr_val_s = rd_val_s - rs_val_s;
          2'b10:   wr_val_s = rd_val_s & rs_val_s;
          2'b11:   wr_val_s = rd_val_s | rs_val_s;
          default: wr_val_s = '0;
        endcase
      end
      OP_JMP:  jmp_s = 1'b1;
`ifdef NAIVE_CPU_HALT_EN
      OP_HALT: halt_s = 1'b1;
`endif
      default: wr_en_s = 1'b0;
    endcase
  end

  // Fetch stage: a jump squashes the sequential word arriving on the same edge.
  always_comb begin
    pc_d = pc_q;
    ir_d = ir_q;
    ce_d = 1'b1;
    if (halt_s) begin
      ce_d = 1'b0;
    end else if (!ce_q) begin
      ce_d = 1'b1;
    end else if (jmp_s) begin
      pc_d = {{(PC_W-10){1'b0}}, ir_q[9:0]};
      ir_d = '0;
    end else begin
      pc_d = pc_q + PC_W'(1);
      ir_d = rom_data_i;
    end
  end

  // Pipeline and register-file state; frozen entirely once halted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q  <= '0;
      ir_q  <= '0;
      ce_q  <= 1'b0;
      alu_q <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (!halted_s) begin
      pc_q <= pc_d;
      ir_q <= ir_d;
      ce_q <= ce_d;
      if (wr_en_s) begin
        alu_q <= wr_val_s;
        if (rd_s != '0) regs_q[rd_s] <= wr_val_s;
      end
    end
  end

`ifdef NAIVE_CPU_HALT_EN
  logic halted_q;

  // Sticky halt flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) halted_q <= 1'b0;
    else if (halt_s) halted_q <= 1'b1;
    else halted_q <= halted_q;
  end

  assign halted_s = halted_q;
`else
  assign halted_s = 1'b0;
`endif

  // Debug observation mux.
  always_comb begin
    ob_data_o = '0;
    case (ob_mode_i)
      3'd0:    ob_data_o = (ob_sel == '0) ? '0 : regs_q[ob_sel];
      3'd1:    ob_data_o = pc_q;
      3'd2:    ob_data_o = ir_q;
      3'd3:    ob_data_o = alu_q;
`ifdef NAIVE_CPU_HALT_EN
      3'd4:    ob_data_o = {{(DATA_W-1){1'b0}}, halted_q};
`endif
      default: ob_data_o = '0;
    endcase
  end

endmodule

// File: tb/tb_naive_cpu.sv
// Self-checking bench for naive_cpu: directed test-plan steps plus a random program checked
// cycle by cycle against an instruction-level model of the ISA.
module tb_naive_cpu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] rom_data_i;
  logic [15:0] rom_addr_o;
  logic        rom_ce_o;
  logic [2:0]  ob_mode_i = 3'd0;
  logic [3:0]  ob_sel = 4'd0;
  logic [15:0] ob_data_o;

  logic [15:0] rom_mem [1024];
  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Instruction-level model state
  logic [15:0] m_reg [16];
  logic [15:0] m_pc, m_ir, m_alu;
  bit          m_ce, m_halt;

  naive_cpu dut (
    .clk        (clk),
    .rst        (rst),
    .rom_data_i (rom_data_i),
    .rom_addr_o (rom_addr_o),
    .rom_ce_o   (rom_ce_o),
    .ob_mode_i  (ob_mode_i),
    .ob_sel     (ob_sel),
    .ob_data_o  (ob_data_o)
  );

  always #20 clk = ~clk;

  assign rom_data_i = rom_mem[rom_addr_o[9:0]];

  task automatic check(input string tag, input logic [15:0] obs_v, input logic [15:0] exp_v);
    n_chk++;
    assert (obs_v === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs_v, exp_v);
    end
  endtask

  task automatic observe(input logic [2:0] m, input logic [3:0] s, output logic [15:0] v);
    ob_mode_i = m;
    ob_sel    = s;
    #1;
    v = ob_data_o;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_reg[i] = 16'h0000;
    m_pc = 16'h0000; m_ir = 16'h0000; m_alu = 16'h0000;
    m_ce = 1'b0; m_halt = 1'b0;
  endtask

  // One clock of the ISA: run the instruction in IR, then fetch (or redirect).
  task automatic model_step();
    int op, rd, rs, fn, imm6, simm, a, b, res;
    bit wr, jmp;
    if (m_halt) return;
    if (!m_ce) begin
      m_ce = 1'b1;
      return;
    end
    op = int'(m_ir[15:10]); rd = int'(m_ir[9:6]); rs = int'(m_ir[5:2]);
    fn = int'(m_ir[1:0]); imm6 = int'(m_ir[5:0]);
    simm = (imm6 >= 32) ? imm6 - 64 : imm6;
    a = int'(m_reg[rd]); b = int'(m_reg[rs]);
    wr = 1'b0; jmp = 1'b0; res = 0;
    case (op)
      13: begin wr = 1'b1; res = a | imm6; end
      12: begin wr = 1'b1; res = a & imm6; end
      14: begin wr = 1'b1; res = a ^ imm6; end
      8:  begin wr = 1'b1; res = (a + simm) & 32'h0000FFFF; end
      1: begin
        wr = 1'b1;
        if (fn == 0) res = (a + b) & 32'h0000FFFF;
        else if (fn == 1) res = (a - b) & 32'h0000FFFF;
        else if (fn == 2) res = a & b;
        else res = a | b;
      end
      4: jmp = 1'b1;
`ifdef NAIVE_CPU_HALT_EN
      63: begin
        m_halt = 1'b1;
        m_ce   = 1'b0;
        return;
      end
`endif
      default: wr = 1'b0;
    endcase
    if (wr) begin
      m_alu = res[15:0];
      if (rd != 0) m_reg[rd] = res[15:0];
    end
    if (jmp) begin
      m_pc = {6'd0, m_ir[9:0]};
      m_ir = 16'h0000;
    end else begin
      m_ir = rom_mem[m_pc[9:0]];
      m_pc = m_pc + 16'd1;
    end
  endtask

  task automatic check_all();
    logic [15:0] v;
    logic [3:0]  k;
    logic [2:0]  z;
    check("pc", rom_addr_o, m_pc);
    check("ce", {15'd0, rom_ce_o}, {15'd0, m_ce});
    observe(3'd1, 4'd0, v); check("ob_pc", v, m_pc);
    observe(3'd2, 4'd0, v); check("ob_ir", v, m_ir);
    observe(3'd3, 4'd0, v); check("ob_alu", v, m_alu);
    k = 4'($urandom_range(0, 15));
    observe(3'd0, k, v); check("ob_reg", v, m_reg[k]);
`ifdef NAIVE_CPU_HALT_EN
    observe(3'd4, 4'd0, v); check("ob_halt", v, {15'd0, m_halt});
`else
    observe(3'd4, 4'd0, v); check("ob_m4", v, 16'h0000);
`endif
    z = 3'($urandom_range(5, 7));
    observe(z, k, v); check("ob_hi", v, 16'h0000);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [15:0] rand_inst();
    logic [15:0] w;
    logic [5:0]  op;
    w = 16'($urandom);
    case ($urandom_range(0, 15))
      0:         op = 6'd0;
      1, 2, 13:  op = 6'd13;
      3:         op = 6'd12;
      4, 14:     op = 6'd14;
      5, 6:      op = 6'd8;
      7, 8, 9:   op = 6'd1;
      10:        op = 6'd4;
`ifdef NAIVE_CPU_HALT_EN
      11:        op = 6'd62;
`else
      11:        op = 6'd63;
`endif
      12:        op = 6'($urandom_range(16, 62));
      default:   op = 6'd13;
    endcase
    return {op, w[9:0]};
  endfunction

  initial begin
    logic [15:0] v;

    // Directed program
    for (int i = 0; i < 1024; i++) rom_mem[i] = 16'h0000;
    rom_mem[0]  = 16'h3443;  // ORI  r1,3
    rom_mem[1]  = 16'h20BF;  // ADDI r2,-1
    rom_mem[2]  = 16'h0485;  // SUB  r2,r1
    rom_mem[5]  = 16'h1020;  // JMP  0x020
    rom_mem[6]  = 16'h357F;  // ORI  r5,0x3F (squashed)
    rom_mem[32] = 16'h38D5;  // XORI r3,0x15

    model_reset();
    rst = 1'b0;
    repeat (4) tick();
    for (int m = 0; m < 8; m++) begin
      observe(3'(m), 4'd1, v); check("rst_ob", v, 16'h0000);
    end
    check("rst_addr", rom_addr_o, 16'h0000);
    check("rst_ce", {15'd0, rom_ce_o}, 16'h0000);

    rst = 1'b1;
    tick();
    check("ce_up", {15'd0, rom_ce_o}, 16'h0001);
    check("pc_first", rom_addr_o, 16'h0000);
    tick();
    check("pc_inc", rom_addr_o, 16'h0001);
    observe(3'd0, 4'd1, v); check("r1_before", v, 16'h0000);
    tick();
    observe(3'd0, 4'd1, v); check("r1_ori", v, 16'h0003);
    observe(3'd3, 4'd0, v); check("alu_ori", v, 16'h0003);
    observe(3'd0, 4'd0, v); check("r0_zero", v, 16'h0000);
    tick();
    observe(3'd0, 4'd2, v); check("r2_addi", v, 16'hFFFF);
    tick();
    observe(3'd0, 4'd2, v); check("r2_sub", v, 16'hFFFC);
    repeat (3) tick();
    check("jmp_tgt", rom_addr_o, 16'h0020);
    tick();
    check("jmp_next", rom_addr_o, 16'h0021);
    tick();
    observe(3'd0, 4'd3, v); check("r3_xori", v, 16'h0015);
    observe(3'd0, 4'd5, v); check("r5_squash", v, 16'h0000);

    // Asynchronous reset between edges
    rst = 1'b0;
    model_reset();
    #1;
    observe(3'd0, 4'd1, v); check("arst_r1", v, 16'h0000);
    observe(3'd2, 4'd0, v); check("arst_ir", v, 16'h0000);
    check("arst_pc", rom_addr_o, 16'h0000);
    check("arst_ce", {15'd0, rom_ce_o}, 16'h0000);

    // Random program against the model
    for (int i = 0; i < 1024; i++) rom_mem[i] = rand_inst();
    repeat (2) tick();
    rst = 1'b1;
    repeat (400) tick();
    for (int r = 0; r < 16; r++) begin
      observe(3'd0, 4'(r), v); check("rand_reg", v, m_reg[r]);
    end

    // HALT at address 2
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 1024; i++) rom_mem[i] = 16'h3443;
    rom_mem[2] = 16'hFC00;
    repeat (2) tick();
    rst = 1'b1;
    repeat (6) tick();
`ifdef NAIVE_CPU_HALT_EN
    check("halt_pc", rom_addr_o, 16'h0003);
    check("halt_ce", {15'd0, rom_ce_o}, 16'h0000);
    observe(3'd4, 4'd0, v); check("halt_m4", v, 16'h0001);
`else
    check("nohalt_pc", rom_addr_o, 16'h0005);
    check("nohalt_ce", {15'd0, rom_ce_o}, 16'h0001);
    observe(3'd4, 4'd0, v); check("nohalt_m4", v, 16'h0000);
`endif
    observe(3'd0, 4'd1, v); check("halt_r1", v, 16'h0003);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
